// File: rtl/comparator_stream_pipelined_pkg.sv
// Shared types for the pipelined stream comparator: compare mode, ALU flags
// of A-B, and the decoded relation set.
package comparator_pkg;

    typedef enum logic {
        CMP_UNSIGNED = 1'b0,
        CMP_SIGNED   = 1'b1
    } cmp_mode_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } cmp_flags_t;

    typedef struct packed {
        logic eq;
        logic ne;
        logic lt;
        logic le;
        logic gt;
        logic ge;
    } cmp_rel_t;

endpackage

// File: rtl/comparator_stream_pipelined_if.sv
// Operand/result stream bundle for comparator_stream_pipelined.
// COMPARATOR_STREAM_MINMAX_EN adds the running min/max sideband signals.
interface comparator_stream_pipelined_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_signed;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [TAG_W-1:0] out_tag;
    logic             out_eq, out_ne, out_lt, out_le, out_gt, out_ge;
    logic             out_n, out_z, out_c, out_v;
`ifdef COMPARATOR_STREAM_MINMAX_EN
    logic             minmax_clear;
    logic [WIDTH-1:0] run_min;
    logic [WIDTH-1:0] run_max;
    logic             run_seen;

    modport slave (
        input  in_valid, in_a, in_b, in_signed, in_tag, out_ready, minmax_clear,
        output in_ready, out_valid, out_tag,
               out_eq, out_ne, out_lt, out_le, out_gt, out_ge,
               out_n, out_z, out_c, out_v, run_min, run_max, run_seen
    );
    modport master (
        output in_valid, in_a, in_b, in_signed, in_tag, out_ready, minmax_clear,
        input  in_ready, out_valid, out_tag,
               out_eq, out_ne, out_lt, out_le, out_gt, out_ge,
               out_n, out_z, out_c, out_v, run_min, run_max, run_seen
    );
`else
    modport slave (
        input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
        output in_ready, out_valid, out_tag,
               out_eq, out_ne, out_lt, out_le, out_gt, out_ge,
               out_n, out_z, out_c, out_v
    );
    modport master (
        output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
        input  in_ready, out_valid, out_tag,
               out_eq, out_ne, out_lt, out_le, out_gt, out_ge,
               out_n, out_z, out_c, out_v
    );
`endif
endinterface

// File: rtl/comparator_stream_pipelined_flag_decode.sv
// Combinational decode of A-B flags into the relation set under a compare mode.
module comparator_flag_decode
    import comparator_pkg::*;
(
    input  cmp_flags_t flags,
    input  cmp_mode_t  mode,
    output cmp_rel_t   rel
);
    logic slt;

    always_comb begin
        rel    = '0;
        slt    = flags.n ^ flags.v;
        rel.eq = flags.z;
        rel.ne = ~flags.z;
        if (mode == CMP_SIGNED) begin
            rel.lt = slt;
            rel.ge = ~slt;
            rel.le = flags.z | slt;
            rel.gt = ~flags.z & ~slt;
        end else begin
            rel.lt = ~flags.c;
            rel.ge = flags.c;
            rel.le = flags.z | ~flags.c;
            rel.gt = flags.c & ~flags.z;
        end
    end
endmodule

// File: rtl/comparator_stream_pipelined.sv
// Two-stage valid/ready comparator: S1 captures operands, S2 holds A-B flags.
// COMPARATOR_STREAM_MINMAX_EN enables running min/max tracking of A on output.
module comparator_stream_pipelined
    import comparator_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TAG_W = 4
) (
    input logic                          clk,
    input logic                          reset,
    comparator_stream_pipelined_if.slave bus
);
    function automatic cmp_flags_t sub_flags(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        logic [WIDTH:0] sum;
        cmp_flags_t     f;
        sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        f.n = sum[WIDTH-1];
        f.z = (sum[WIDTH-1:0] == '0);
        f.c = sum[WIDTH];
        f.v = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ sum[WIDTH-1]);
        return f;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    cmp_mode_t        s1_mode_q, s1_mode_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    cmp_flags_t       s2_flags_q, s2_flags_d;
    cmp_mode_t        s2_mode_q, s2_mode_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic             s2_can_load, in_ready, in_hs, s1_adv;
    cmp_rel_t         rel;

    always_comb begin
        s2_can_load = ~s2_valid_q | bus.out_ready;
        in_ready    = ~s1_valid_q | s2_can_load;
        in_hs       = bus.in_valid & in_ready;
        s1_adv      = s1_valid_q & s2_can_load;

        s1_valid_d  = in_ready ? bus.in_valid : s1_valid_q;
        s1_a_d      = in_hs ? bus.in_a   : s1_a_q;
        s1_b_d      = in_hs ? bus.in_b   : s1_b_q;
        s1_tag_d    = in_hs ? bus.in_tag : s1_tag_q;
        s1_mode_d   = s1_mode_q;
        if (in_hs) s1_mode_d = bus.in_signed ? CMP_SIGNED : CMP_UNSIGNED;

        s2_valid_d  = s2_can_load ? s1_valid_q : s2_valid_q;
        s2_flags_d  = s1_adv ? sub_flags(s1_a_q, s1_b_q) : s2_flags_q;
        s2_mode_d   = s1_adv ? s1_mode_q : s2_mode_q;
        s2_tag_d    = s1_adv ? s1_tag_q  : s2_tag_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_mode_q  <= CMP_UNSIGNED;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_flags_q <= '0;
            s2_mode_q  <= CMP_UNSIGNED;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_mode_q  <= s1_mode_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_flags_q <= s2_flags_d;
            s2_mode_q  <= s2_mode_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    comparator_flag_decode u_dec (
        .flags (s2_flags_q),
        .mode  (s2_mode_q),
        .rel   (rel)
    );

    // Result fields are masked while S2 is empty so idle outputs read as zero.
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_tag   = s2_valid_q ? s2_tag_q : '0;
    assign bus.out_eq    = s2_valid_q & rel.eq;
    assign bus.out_ne    = s2_valid_q & rel.ne;
    assign bus.out_lt    = s2_valid_q & rel.lt;
    assign bus.out_le    = s2_valid_q & rel.le;
    assign bus.out_gt    = s2_valid_q & rel.gt;
    assign bus.out_ge    = s2_valid_q & rel.ge;
    assign bus.out_n     = s2_valid_q & s2_flags_q.n;
    assign bus.out_z     = s2_valid_q & s2_flags_q.z;
    assign bus.out_c     = s2_valid_q & s2_flags_q.c;
    assign bus.out_v     = s2_valid_q & s2_flags_q.v;

`ifdef COMPARATOR_STREAM_MINMAX_EN
    logic [WIDTH-1:0] s2_a_q, s2_a_d;
    logic [WIDTH-1:0] run_min_q, run_min_d;
    logic [WIDTH-1:0] run_max_q, run_max_d;
    logic             run_seen_q, run_seen_d;
    logic             out_hs;
    cmp_rel_t         rel_min, rel_max;

    // Compare the departing A against each extreme using that result's own mode.
    comparator_flag_decode u_dec_min (
        .flags (sub_flags(s2_a_q, run_min_q)),
        .mode  (s2_mode_q),
        .rel   (rel_min)
    );
    comparator_flag_decode u_dec_max (
        .flags (sub_flags(s2_a_q, run_max_q)),
        .mode  (s2_mode_q),
        .rel   (rel_max)
    );

    always_comb begin
        out_hs     = s2_valid_q & bus.out_ready;
        s2_a_d     = s1_adv ? s1_a_q : s2_a_q;
        run_min_d  = run_min_q;
        run_max_d  = run_max_q;
        run_seen_d = run_seen_q;
        if (bus.minmax_clear) begin
            run_seen_d = 1'b0;
        end else if (out_hs) begin
            run_seen_d = 1'b1;
            if (!run_seen_q || rel_min.lt) run_min_d = s2_a_q;
            if (!run_seen_q || rel_max.gt) run_max_d = s2_a_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_a_q     <= '0;
            run_min_q  <= '0;
            run_max_q  <= '0;
            run_seen_q <= 1'b0;
        end else begin
            s2_a_q     <= s2_a_d;
            run_min_q  <= run_min_d;
            run_max_q  <= run_max_d;
            run_seen_q <= run_seen_d;
        end
    end

    assign bus.run_min  = run_min_q;
    assign bus.run_max  = run_max_q;
    assign bus.run_seen = run_seen_q;
`endif
endmodule

// File: tb/tb_comparator_stream_pipelined.sv
// Self-checking bench for comparator_stream_pipelined: directed table, random
// stream against an arithmetic reference model, stall/reset/minmax sequences.
module tb_comparator_stream_pipelined;
    import comparator_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned TW = 4;

    logic clk = 1'b0;
    logic reset;

    comparator_stream_pipelined_if #(.WIDTH(W), .TAG_W(TW)) bus ();

    comparator_stream_pipelined #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]    rel;   // {eq,ne,lt,le,gt,ge}
        logic [3:0]    flg;   // {n,z,c,v}
        logic [TW-1:0] tag;
    } res_t;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          sgn;
        logic [TW-1:0] tag;
        logic [5:0]    rel;
        logic [3:0]    flg;
    } vec_t;

    res_t exp_q[$];
    res_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   n_acc  = 0;
    int   n_out  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sgn, input logic [TW-1:0] tag);
        int   ua, ub, sa, sb, x, y, d;
        res_t r;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        x  = sgn ? sa : ua;
        y  = sgn ? sb : ub;
        d  = sa - sb;
        r.rel = {x == y, x != y, x < y, x <= y, x > y, x >= y};
        r.flg = {((ua - ub) & ((1 << W) - 1)) >= (1 << (W - 1)),
                 ua == ub,
                 ua >= ub,
                 (d > (1 << (W - 1)) - 1) || (d < -(1 << (W - 1)))};
        r.tag = tag;
        return r;
    endfunction

    function automatic res_t observe();
        res_t r;
        r.rel = {bus.out_eq, bus.out_ne, bus.out_lt, bus.out_le, bus.out_gt, bus.out_ge};
        r.flg = {bus.out_n, bus.out_z, bus.out_c, bus.out_v};
        r.tag = bus.out_tag;
        return r;
    endfunction

    // Scoreboard: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output got=%0h exp=none", observe());
                end else begin
                    mon_e = exp_q.pop_front();
                    check("stream_result", observe(), mon_e);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                n_acc++;
                exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_signed, bus.in_tag));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sgn, input logic [TW-1:0] tag);
        logic hs;
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_signed = sgn;
        bus.in_tag    = tag;
        hs = 1'b0;
        for (int k = 0; k < 20 && !hs; k++) begin
            hs = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got=0 exp=1");
        end
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 50; k++) begin
            if (exp_q.size() == 0 && !bus.out_valid) break;
            tick();
        end
        check(name, exp_q.size(), 0);
    endtask

    vec_t vecs[6];
    res_t snap;
    int   base_acc, base_out;

    initial begin
        vecs[0] = '{8'h80, 8'h01, 1'b0, 4'd3, 6'b010011, 4'b0011};
        vecs[1] = '{8'h80, 8'h01, 1'b1, 4'd5, 6'b011100, 4'b0011};
        vecs[2] = '{8'h7F, 8'h7F, 1'b0, 4'd6, 6'b100101, 4'b0110};
        vecs[3] = '{8'h7F, 8'h7F, 1'b1, 4'd7, 6'b100101, 4'b0110};
        vecs[4] = '{8'h00, 8'hFF, 1'b0, 4'd8, 6'b011100, 4'b0000};
        vecs[5] = '{8'h00, 8'hFF, 1'b1, 4'd9, 6'b010011, 4'b0000};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_signed = 1'b0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
`ifdef COMPARATOR_STREAM_MINMAX_EN
        bus.minmax_clear = 1'b0;
`endif
        repeat (3) tick();
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_outputs", observe(), 0);
        reset = 1'b0;
        tick();

        // Directed table: 2-cycle latency and exact relation/flag values.
        for (int i = 0; i < 6; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_a      = vecs[i].a;
            bus.in_b      = vecs[i].b;
            bus.in_signed = vecs[i].sgn;
            bus.in_tag    = vecs[i].tag;
            check("vec_in_ready", bus.in_ready, 1);
            tick();
            bus.in_valid = 1'b0;
            check("vec_lat1_valid", bus.out_valid, 0);
            tick();
            check("vec_lat2_valid", bus.out_valid, 1);
            check("vec_rel", {bus.out_eq, bus.out_ne, bus.out_lt, bus.out_le, bus.out_gt, bus.out_ge}, vecs[i].rel);
            check("vec_flags", {bus.out_n, bus.out_z, bus.out_c, bus.out_v}, vecs[i].flg);
            check("vec_tag", bus.out_tag, vecs[i].tag);
        end
        drain("vec_drain");

        // Back-to-back random stream at full throughput.
        base_out = n_out;
        for (int i = 0; i < 16; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_a      = W'($urandom);
            bus.in_b      = (i % 4 == 0) ? bus.in_a : W'($urandom);
            bus.in_signed = 1'($urandom);
            bus.in_tag    = TW'(i);
            check("rand_in_ready", bus.in_ready, 1);
            if (i >= 2) check("rand_out_valid", bus.out_valid, 1);
            tick();
        end
        bus.in_valid = 1'b0;
        drain("rand_drain");
        check("rand_count", n_out - base_out, 16);

        // Backpressure: 5 cycles of out_ready=0 with continuous input.
        base_acc = n_acc;
        base_out = n_out;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.in_valid  = 1'b1;
            bus.in_a      = W'($urandom);
            bus.in_b      = W'($urandom);
            bus.in_signed = 1'($urandom);
            bus.in_tag    = TW'(10 + k);
            tick();
            if (k == 1) snap = observe();
        end
        check("stall_accepted", n_acc - base_acc, 2);
        check("stall_in_ready", bus.in_ready, 0);
        check("stall_out_valid", bus.out_valid, 1);
        check("stall_stable", observe(), snap);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain("stall_drain");
        check("stall_emitted", n_out - base_out, 2);

        // Reset with two transactions held.
        bus.out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b0, 4'd1);
        send(8'h56, 8'h78, 1'b1, 4'd2);
        check("hold_two", exp_q.size(), 2);
        reset = 1'b1;
        #1;
        check("rst_mid_out_valid", bus.out_valid, 0);
        check("rst_mid_in_ready", bus.in_ready, 1);
        tick();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        base_out = n_out;
        repeat (5) tick();
        check("rst_mid_no_emit", n_out - base_out, 0);
        check("rst_mid_idle", bus.out_valid, 0);

`ifdef COMPARATOR_STREAM_MINMAX_EN
        check("mm_reset_seen", bus.run_seen, 0);
        send(8'd5, 8'd0, 1'b1, 4'd1);
        send(8'hFD, 8'd0, 1'b1, 4'd2);
        send(8'd100, 8'd0, 1'b1, 4'd3);
        send(8'h80, 8'd0, 1'b1, 4'd4);
        drain("mm_drain");
        check("mm_min", bus.run_min, 8'h80);
        check("mm_max", bus.run_max, 8'h64);
        check("mm_seen", bus.run_seen, 1);
        bus.minmax_clear = 1'b1;
        tick();
        bus.minmax_clear = 1'b0;
        check("mm_clear_seen", bus.run_seen, 0);
        send(8'd7, 8'd0, 1'b1, 4'd5);
        drain("mm_drain2");
        check("mm_min_after_clear", bus.run_min, 8'd7);
        check("mm_max_after_clear", bus.run_max, 8'd7);
        check("mm_seen_after", bus.run_seen, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/comparator_stream_pipelined.md
Name: comparator_stream_pipelined

Overview:
- Parametrised, two-stage pipelined magnitude/equality comparator with a selectable signed/unsigned mode per transaction.
- Uses valid/ready handshakes on input and output.
- Produces the full relation set (eq, ne, lt, le, gt, ge) and the raw ALU flags (n, z, c, v) from a registered A−B subtraction.
- Sits between operand-producing datapath stages and branch/select logic that must tolerate backpressure.

Parameters:
- WIDTH, 8, operand width in bits (≥2)
- TAG_W, 4, width of a sideband tag carried alongside each transaction

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_signed  input  1  1 = two's-complement compare, 0 = unsigned
- in_tag  input  TAG_W  sideband tag, returned unchanged
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_tag  output  TAG_W  tag of this result
- out_eq, out_ne, out_lt, out_le, out_gt, out_ge  output  1 each  relation A?B under that transaction's mode
- out_n, out_z, out_c, out_v  output  1 each  flags of A−B (c = no-borrow)

Behaviour:
- Reset: all stage-valid bits clear, so out_valid=0 and in_ready=1 after reset. All outputs are 0 except in_ready. Reset asserted mid-operation discards every in-flight transaction.
- Stage 1 (S1) captures in_a, in_b, in_signed and in_tag on an input handshake (in_valid & in_ready).
- Stage 2 (S2) registers:
  - the (WIDTH+1)-bit sum A + ~B + 1
  - n = sum[WIDTH-1]
  - z = (sum[WIDTH-1:0] == 0)
  - c = sum[WIDTH]
  - v = (A[msb] ^ B[msb]) & (A[msb] ^ sum[WIDTH-1])
  - the mode and the tag
- Relation outputs are decoded combinationally from the S2 flags:
  - unsigned: ge=c, lt=~c, le=z|~c, gt=c&~z
  - signed: ge=~(n^v), lt=n^v, le=z|(n^v), gt=~z&~(n^v)
  - both modes: eq=z, ne=~z
- Signed results are correct across overflow, e.g. −128 vs 1.
- Latency: 2 cycles from input handshake to out_valid when not stalled. Throughput is 1 transaction per cycle.
- Stage advance rules:
  - S2 loads when S2 is empty or (out_valid & out_ready).
  - S1 loads when S1 is empty or S1 advances into S2 in the same cycle.
  - in_ready = ~s1_valid | s2_can_load, which is combinational from out_ready.
- Outputs are held stable while out_valid & ~out_ready.
- A stalled pipeline holds at most 2 transactions.
- When out_valid & ~out_ready and S1 is full, in_ready=0.
- An input handshake and an output handshake in the same cycle both proceed. No bubble is inserted.
- Ordering: results leave strictly in acceptance order. The tag identifies them.

Optional Feature:
- Macro: COMPARATOR_STREAM_MINMAX_EN.
- When defined, the block adds these ports:
  - minmax_clear (input, 1)
  - run_min and run_max (output, WIDTH each)
  - run_seen (output, 1)
- For every result that leaves S2 via an output handshake:
  - if run_seen=0, both run_min and run_max load A
  - otherwise run_min/run_max update to A when out_lt/out_gt holds, comparing against the current extreme using that transaction's mode
- minmax_clear clears run_seen. It wins over a same-cycle update.
- Reset: run_min, run_max and run_seen are all 0.
- Without the macro these ports and this logic do not exist. Core behaviour is identical either way.

Decomposition:
- Package comparator_pkg:
  - typedef enum cmp_mode_t {CMP_UNSIGNED, CMP_SIGNED}
  - packed struct cmp_flags_t {n, z, c, v}
  - packed struct cmp_rel_t {eq, ne, lt, le, gt, ge}
- One sub-module, comparator_flag_decode: combinational, maps cmp_flags_t plus cmp_mode_t to cmp_rel_t. It is reused by the minmax logic.

Test Plan:
- Reset mid-stream with 2 transactions held → out_valid=0 next cycle, in_ready=1, nothing emitted after reset release.
- WIDTH=8, unsigned, A=0x80, B=0x01, tag=3 → after 2 cycles: gt=1, ge=1, lt=0, c=1, z=0, tag=3.
- Same operands, signed (−128 vs 1) → lt=1, le=1, gt=0, v=1, n=0. Then A=B=0x7F in either mode → eq=1, z=1, c=1.
- Back-to-back 16 random pairs, out_ready=1 → one result per cycle, in order, every relation matches a reference model in both modes.
- out_ready held 0 for 5 cycles with in_valid=1 → exactly 2 accepted, in_ready=0 after the second, outputs stable. Release → results drain in order with no loss or duplication.
- MINMAX_EN: signed stream A = 5, −3, 100, −128 → run_min=0x80, run_max=0x64. Then minmax_clear → run_seen=0, and the next A=7 → run_min=run_max=7.
